l1_icache: RTL and testbench
============================

# l1_icache

Direct-mapped, read-only L1 instruction cache that sits directly upstream of the pipelined LC-3b datapath's fetch stage. It supplies the 128-bit instruction line the datapath indexes by PC, and it refills from physical memory on a miss. While a miss is outstanding, the datapath stalls on `mem_resp` low. The block also keeps saturating hit and miss counters and supports a whole-cache flush.

## Interface
Parameters:
- `NUM_SETS`, default 8: number of lines; must be a power of 2. `IDX = log2(NUM_SETS)`.
- `OFFSET_BITS`, default 4: byte offset within a 128-bit line.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_address` in 16 (lc3b_word): fetch address (the PC).
- `mem_read` in 1: fetch request; held with a stable address until `mem_resp`.
- `mem_rdata` out 128 (lc3b_line): line containing `mem_address`.
- `mem_resp` out 1: `mem_rdata` is valid this cycle.
- `flush` in 1: invalidate all lines.
- `pmem_address` out 16: line-aligned refill address.
- `pmem_read` out 1: refill request.
- `pmem_rdata` in 128: refill line.
- `pmem_resp` in 1: `pmem_rdata` is valid; single-cycle pulse.
- `hit_count` out 16: saturating hit counter.
- `miss_count` out 16: saturating miss counter.

## Operation
- Address split:
  - offset = `[OFFSET_BITS-1:0]`
  - index = `[OFFSET_BITS+IDX-1:OFFSET_BITS]`
  - tag = `[15:OFFSET_BITS+IDX]`
  - Defaults give offset [3:0], index [6:4], tag [15:7] (9 bits).
- Storage per set: valid bit, tag, 128-bit data. Valid bits reset to 0. Tag and data arrays are not reset.
- `hit` = `mem_read` && state==IDLE && valid[index] && tag[index]==addr tag.
- Outputs:
  - `mem_resp` = `hit`, combinational.
  - `mem_rdata` = data[index] when `hit`, else 128'h0.
- State machine, two states:
  - IDLE:
    - `mem_read` && !`hit` && !`flush` → FETCH, and `miss_count` increments.
    - `hit` → `hit_count` increments; stay IDLE.
  - FETCH:
    - `pmem_read` = 1 and `pmem_address` = {req tag, req index, 4'b0}. Both are registered at FETCH entry and held constant through FETCH.
    - On `pmem_resp`: write data[idx] = `pmem_rdata` and tag[idx] = req tag, set valid[idx] = !poison, clear poison, → IDLE.
- Flush:
  - A cycle with `flush`=1 clears all valid bits at the edge.
  - In IDLE, `flush` suppresses `hit` and miss entry that cycle (`mem_resp` = 0).
  - In FETCH, `flush` sets the poison flag. The refill still completes and writes data/tag, but leaves valid = 0, so the held request misses again and refetches.
  - `flush` coincident with `pmem_resp`: the line is installed invalid.
- Abandonment: if `mem_read` drops during FETCH, the refill still completes and installs normally.
- Counters:
  - 16-bit; they stick at 16'hFFFF and never wrap.
  - Reset to 0.
  - `hit_count` increments once per cycle in which `mem_resp`=1. `miss_count` increments once per IDLE→FETCH transition.

## Timing
- Reset, asynchronous:
  - state=IDLE, all valid=0, poison=0, counters=0.
  - `pmem_read`=0, `mem_resp`=0, `mem_rdata`=0, `pmem_address`=16'h0.
  - Reset asserted during FETCH aborts the refill immediately; a late `pmem_resp` in IDLE is ignored.
- Hit latency: 0 cycles; `mem_resp` is in the same cycle as `mem_read`.
- Miss latency:
  - Cycle 0 detects the miss.
  - `pmem_read` is high from cycle 1 until the cycle of `pmem_resp` (cycle k), and deasserts the cycle after.
  - Cycle k+1 is IDLE and the request hits: `mem_resp`=1.
  - Minimum miss latency is 2 cycles, when `pmem_resp` arrives in cycle 1.
- Only one refill is outstanding at a time; `mem_read` is not looked up in FETCH (`mem_resp`=0).
- Set conflicts: two addresses with the same index and different tags evict each other; there is no victim buffer.

## Test plan
- Reset then read 0x3000: `mem_resp`=0, FETCH, `pmem_address`=0x3000. Memory returns line L after 3 cycles → `mem_resp`=1 with `mem_rdata`=L one cycle later; `miss_count`=1, `hit_count`=1.
- Reads 0x3002, then 0x300E after the line is filled: same-cycle `mem_resp`, `mem_rdata`=L both times, no `pmem_read`; `hit_count` increments by 2.
- Conflict: 0x3000 and then 0x3080 (index 0, tags differ): second read refills and evicts; rereading 0x3000 misses again; `miss_count`=3.
- `flush` for one cycle in IDLE after filling 0x3000: next read of 0x3000 misses. `flush` during FETCH: after `pmem_resp`, valid stays 0, so a second `pmem_read` is issued for the same address.
- `reset` asserted mid-FETCH: `pmem_read` drops the same cycle and counters read 0. A `pmem_resp` pulse after `reset` deasserts does not set valid.
- Preload `hit_count` to 0xFFFE via repeated hits, then 3 more hits: `hit_count` stays at 0xFFFF.

Source files
------------

// File: rtl/l1_icache_if.sv
// Fetch-side and refill-side signal bundle for the L1 instruction cache.
// The slave modport is the cache's view; master is the datapath/memory side.
interface l1_icache_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         flush;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    modport slave (
        input  mem_address, mem_read, flush, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, hit_count, miss_count
    );

    modport master (
        output mem_address, mem_read, flush, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, hit_count, miss_count
    );
endinterface

// File: rtl/l1_icache.sv
// Direct-mapped read-only L1 instruction cache with single outstanding refill,
// whole-cache flush (with in-flight poisoning) and saturating hit/miss counters.
module l1_icache #(
    parameter int NUM_SETS    = 8,
    parameter int OFFSET_BITS = 4
) (
    input  logic          clk,
    input  logic          reset,
    l1_icache_if.slave    bus
);
    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = 16 - OFFSET_BITS - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];
    logic                poison_q;
    logic [TAG_W-1:0]    req_tag_q;
    logic [IDX-1:0]      req_idx_q;
    logic [15:0]         hit_count_q, miss_count_q;

    logic [TAG_W-1:0]    addr_tag;
    logic [IDX-1:0]      addr_idx;
    logic                hit, miss_start, fill, pmem_read;
    logic                unused_offset;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign addr_tag = bus.mem_address[15:OFFSET_BITS+IDX];
    assign addr_idx = bus.mem_address[OFFSET_BITS+IDX-1:OFFSET_BITS];
    // Byte offset only selects within the line, which the datapath does itself.
    assign unused_offset = ^bus.mem_address[OFFSET_BITS-1:0];

    assign fill = (state_q == FETCH) && bus.pmem_resp;

    always_comb begin
        state_d    = state_q;
        hit        = 1'b0;
        miss_start = 1'b0;
        pmem_read  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read && !bus.flush) begin
                    if (valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag)) begin
                        hit = 1'b1;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_resp     = hit;
    assign bus.mem_rdata    = hit ? data_q[addr_idx] : 128'h0;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_address = {req_tag_q, req_idx_q, {OFFSET_BITS{1'b0}}};
    assign bus.hit_count    = hit_count_q;
    assign bus.miss_count   = miss_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            poison_q     <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                req_tag_q    <= addr_tag;
                req_idx_q    <= addr_idx;
                miss_count_q <= sat_inc(miss_count_q);
            end
            if (hit) begin
                hit_count_q <= sat_inc(hit_count_q);
            end
            // A flush landing on the fill edge still leaves the new line invalid.
            if (bus.flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[req_idx_q] <= !poison_q;
            end
            if (fill) begin
                poison_q <= 1'b0;
            end else if ((state_q == FETCH) && bus.flush) begin
                poison_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[req_idx_q]  <= req_tag_q;
            data_q[req_idx_q] <= bus.pmem_rdata;
        end
    end
endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: misses/refills, hits, conflicts, flush,
// mid-refill reset, abandonment and counter saturation.
module tb_l1_icache;
    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    l1_icache_if bus();

    l1_icache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] L0  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] L1  = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234;
    localparam logic [127:0] L0B = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    localparam logic [127:0] L2  = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
    localparam logic [127:0] L3  = 128'h5A5A_5A5A_A5A5_A5A5_5A5A_5A5A_A5A5_A5A5;
    localparam logic [127:0] L4  = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] L5  = 128'h1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Miss on addr, return line after wait_cycles extra FETCH cycles, then see the hit.
    task automatic do_miss(input logic [15:0] addr, input logic [127:0] line, input int wait_cycles);
        bus.mem_read    = 1'b1;
        bus.mem_address = addr;
        #4;
        check("miss_resp", {127'b0, bus.mem_resp}, 128'd0);
        step();
        check("miss_pmem_read", {127'b0, bus.pmem_read}, 128'd1);
        check("miss_pmem_addr", {112'b0, bus.pmem_address}, {112'b0, addr[15:4], 4'b0});
        repeat (wait_cycles) step();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line;
        step();
        bus.pmem_resp = 1'b0;
        #4;
        check("refill_resp", {127'b0, bus.mem_resp}, 128'd1);
        check("refill_rdata", bus.mem_rdata, line);
        check("refill_pmem_idle", {127'b0, bus.pmem_read}, 128'd0);
        step();
        bus.mem_read = 1'b0;
    endtask

    task automatic do_hit(input logic [15:0] addr, input logic [127:0] line);
        bus.mem_read    = 1'b1;
        bus.mem_address = addr;
        #4;
        check("hit_resp", {127'b0, bus.mem_resp}, 128'd1);
        check("hit_rdata", bus.mem_rdata, line);
        check("hit_no_pmem", {127'b0, bus.pmem_read}, 128'd0);
        step();
        bus.mem_read = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.mem_address = 16'h0;
        bus.mem_read    = 1'b0;
        bus.flush       = 1'b0;
        bus.pmem_rdata  = 128'h0;
        bus.pmem_resp   = 1'b0;
        step();
        step();
        check("rst_resp", {127'b0, bus.mem_resp}, 128'd0);
        check("rst_rdata", bus.mem_rdata, 128'd0);
        check("rst_pmem_read", {127'b0, bus.pmem_read}, 128'd0);
        check("rst_pmem_addr", {112'b0, bus.pmem_address}, 128'd0);
        check("rst_hits", {112'b0, bus.hit_count}, 128'd0);
        check("rst_misses", {112'b0, bus.miss_count}, 128'd0);
        reset = 1'b0;
        step();

        // Cold miss, memory answers in cycle 3
        do_miss(16'h3000, L0, 2);
        check("first_miss_count", {112'b0, bus.miss_count}, 128'd1);
        check("first_hit_count", {112'b0, bus.hit_count}, 128'd1);

        do_hit(16'h3002, L0);
        do_hit(16'h300E, L0);
        check("hits_after_two", {112'b0, bus.hit_count}, 128'd3);

        // Same index, different tag: evict and re-miss
        do_miss(16'h3080, L1, 0);
        do_miss(16'h3000, L0B, 1);
        check("conflict_misses", {112'b0, bus.miss_count}, 128'd3);
        check("conflict_hits", {112'b0, bus.hit_count}, 128'd5);

        // Flush in IDLE, first alone, then coincident with a read
        bus.flush = 1'b1;
        step();
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3000;
        #4;
        check("flush_suppress_resp", {127'b0, bus.mem_resp}, 128'd0);
        step();
        bus.flush    = 1'b0;
        bus.mem_read = 1'b0;
        check("flush_no_miss", {112'b0, bus.miss_count}, 128'd3);
        check("flush_state_idle", {127'b0, bus.pmem_read}, 128'd0);
        do_miss(16'h3000, L2, 0);
        check("after_flush_misses", {112'b0, bus.miss_count}, 128'd4);

        // Flush during FETCH poisons the refill
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3010;
        step();
        bus.flush = 1'b1;
        check("poison_fetch", {127'b0, bus.pmem_read}, 128'd1);
        step();
        bus.flush      = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = L3;
        step();
        bus.pmem_resp = 1'b0;
        #4;
        check("poison_no_hit", {127'b0, bus.mem_resp}, 128'd0);
        step();
        check("poison_refetch", {127'b0, bus.pmem_read}, 128'd1);
        check("poison_refetch_addr", {112'b0, bus.pmem_address}, 128'h3010);
        check("poison_misses", {112'b0, bus.miss_count}, 128'd6);
        bus.pmem_resp = 1'b1;
        step();
        bus.pmem_resp = 1'b0;
        #4;
        check("poison_final_resp", {127'b0, bus.mem_resp}, 128'd1);
        check("poison_final_rdata", bus.mem_rdata, L3);
        step();
        bus.mem_read = 1'b0;
        check("poison_hits", {112'b0, bus.hit_count}, 128'd7);

        // Reset mid-FETCH, then a stray pmem_resp in IDLE
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3020;
        step();
        check("pre_reset_fetch", {127'b0, bus.pmem_read}, 128'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_pmem", {127'b0, bus.pmem_read}, 128'd0);
        check("reset_pmem_addr", {112'b0, bus.pmem_address}, 128'd0);
        check("reset_hits", {112'b0, bus.hit_count}, 128'd0);
        check("reset_misses", {112'b0, bus.miss_count}, 128'd0);
        step();
        reset          = 1'b0;
        bus.mem_read   = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = L4;
        step();
        bus.pmem_resp = 1'b0;
        do_miss(16'h3020, L4, 0);

        // Requester walks away mid-refill; line still installs
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3030;
        step();
        bus.mem_read   = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = L5;
        step();
        bus.pmem_resp = 1'b0;
        do_hit(16'h3030, L5);
        check("abandon_misses", {112'b0, bus.miss_count}, 128'd2);
        check("abandon_hits", {112'b0, bus.hit_count}, 128'd2);

        // Drive hit_count to saturation
        bus.mem_read = 1'b1;
        repeat (65532) step();
        check("hits_fffe", {112'b0, bus.hit_count}, 128'hFFFE);
        repeat (3) step();
        bus.mem_read = 1'b0;
        check("hits_saturated", {112'b0, bus.hit_count}, 128'hFFFF);
        check("sat_misses", {112'b0, bus.miss_count}, 128'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
